dfr_wr_arb: RTL and testbench
=============================

DFR_WR_ARB -- requirements
Module: dfr_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning width of the shared register and of each write-data bus.
REQ-002 SHALL have parameter N, default 4, meaning number of requesters; supported range 2..8.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear of the shared register.
REQ-006 SHALL have port req  input  N  per-requester write request; bit i belongs to requester i.
REQ-007 SHALL have port lock  input  N  per-requester lock; meaningful only while the matching req bit is high.
REQ-008 SHALL have port wdata  input  N*WIDTH  write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-009 SHALL have port ack  output  N  registered one-hot write acknowledge.
REQ-010 SHALL have port owner  output  $clog2(N)  index of the last granted requester.
REQ-011 SHALL have port locked  output  1  high while in state LOCKED.
REQ-012 SHALL have port q  output  WIDTH  shared register contents.

Function
REQ-013 SHALL arbitrate the write port of one shared WIDTH-bit register between N requesters, granting at most one write per clock.
REQ-014 SHALL use round-robin priority: the search starts at index (ptr+1) mod N and wraps past N-1 to 0; ptr is the last winner.
REQ-015 SHALL, on a rising edge where the winner is i, load q with wdata slice i, set ack to one-hot bit i, set owner and ptr to i.
REQ-016 SHALL set ack to all zeros, and hold q, owner and ptr, on any edge with no grant; ack is therefore a one-cycle pulse per write.
REQ-017 SHALL produce a write latency of one edge: req sampled before edge k, so q and ack valid after edge k.
REQ-018 SHALL implement FSM states IDLE and LOCKED; IDLE -> LOCKED when the winner has lock[i]=1; LOCKED -> IDLE when req[owner]=0 or lock[owner]=0.
REQ-019 SHALL, in LOCKED, grant only requester owner on every edge where req[owner]=1 and lock[owner]=1; all other requests get no ack.
REQ-020 SHALL, on the edge that leaves LOCKED because lock[owner]=0 while req[owner]=1, perform that final write for owner and enter IDLE.
REQ-021 SHALL, on the edge that leaves LOCKED because req[owner]=0, perform no write, return ack to zero and enter IDLE; arbitration resumes on the next edge.
REQ-022 SHALL give clr priority over every write: on an edge with clr=1, q becomes 0, ack becomes 0, and state becomes IDLE; ptr and owner are held.
REQ-023 SHALL ignore lock bits whose req bit is low.
REQ-024 SHALL ignore wdata of non-winning requesters.
REQ-025 SHALL, when only one requester is active, grant it on every edge (back-to-back writes, ack held high).
REQ-026 SHALL drive locked combinationally from the state register only.

Reset
REQ-027 SHALL, on reset_=0, immediately and without a clock force q=0, ack=0, owner=N-1, ptr=N-1, state=IDLE and locked=0, so requester 0 wins first.
REQ-028 SHALL abandon an in-progress locked burst when reset_ is asserted mid-burst; no write occurs while reset_=0.
REQ-029 SHALL be released synchronously by the surrounding system; the block takes its first write on the first edge with reset_=1.

Verification
REQ-030 SHALL pass this scenario: after reset, req=4'b1111, lock=0, wdata slices 0x11/0x22/0x33/0x44 -> ack 0001,0010,0100,1000,0001 on successive edges; q 0x11,0x22,0x33,0x44,0x11.
REQ-031 SHALL pass this scenario: req=4'b0110, lock=4'b0010, all other requests held -> requester 1 wins, locked=1; ack=0010 for 3 edges; drop lock[1] -> final write by 1, then requester 2 wins on the next edge.
REQ-032 SHALL pass this scenario: clr=1 together with req=4'b0001 and wdata=0xAA -> q=0x00, ack=0000; clr=0 on the next edge -> q=0xAA, ack=0001.
REQ-033 SHALL pass this scenario: reset_ pulled low asynchronously mid-cycle during LOCKED with q=0x5C -> q=0, ack=0, locked=0 before the next edge; after release with req=4'b1000 -> ack=1000 on the first edge.
REQ-034 SHALL pass this scenario: only req[2]=1 for 5 edges with wdata incrementing 1..5 -> ack=0100 held, q follows 1..5 with one-edge latency.
REQ-035 SHALL pass this scenario: ptr=N-1 and req=4'b1001 -> requester 0 wins (wrap-around), then requester 3 wins.

Source files
------------

// File: rtl/dfr_wr_arb.sv
// dfr_wr_arb: round-robin write arbiter for one shared register, with lockable bursts
//   clk    - clock, all state changes on the rising edge
//   reset_ - asynchronous active-low reset
//   clr    - synchronous clear of q; overrides any write
//   req    - per-requester write request (bit i = requester i)
//   lock   - per-requester burst lock, only looked at while the matching req is high
//   wdata  - write data, slice [i*WIDTH +: WIDTH] belongs to requester i
//   ack    - registered one-hot write acknowledge
//   owner  - index of the last granted requester (also the round-robin pointer)
//   locked - high while a locked burst holds the register
//   q      - shared register contents
module dfr_wr_arb #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   clr,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           lock,
    input  logic [N*WIDTH-1:0]     wdata,
    output logic [N-1:0]           ack,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   locked,
    output logic [WIDTH-1:0]       q
);
    localparam int W = $clog2(N);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t         state_q, state_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [W-1:0]   owner_q, owner_d, win, gi;
    logic [WIDTH-1:0] data_q, data_d;
    logic           found, g;
    // owner doubles as the round-robin pointer: the search starts just past it
    always_comb begin
        found = 1'b0;
        win   = owner_q;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[W'((int'(owner_q) + k) % N)]) begin
                found = 1'b1;
                win   = W'((int'(owner_q) + k) % N);
            end
        end
    end
    always_comb begin
        g       = (state_q == LOCKED) ? req[owner_q] : found;
        gi      = (state_q == LOCKED) ? owner_q : win;
        state_d = (g && lock[gi] && (state_q == IDLE || req[owner_q])) ? LOCKED : IDLE;
        ack_d   = g ? N'(1) << gi : '0;
        data_d  = g ? wdata[gi*WIDTH +: WIDTH] : data_q;
        owner_d = g ? gi : owner_q;
        if (clr) begin
            state_d = IDLE;
            ack_d   = '0;
            data_d  = '0;
            owner_d = owner_q;
        end
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            ack_q   <= '0;
            owner_q <= W'(N - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            data_q  <= data_d;
        end
    end
    assign ack    = ack_q;
    assign owner  = owner_q;
    assign q      = data_q;
    assign locked = (state_q == LOCKED);
endmodule

// File: tb/tb_dfr_wr_arb.sv
// tb_dfr_wr_arb: directed-vector bench for dfr_wr_arb with N=4, WIDTH=8
module tb_dfr_wr_arb;
    logic        clk = 1'b0;
    logic        reset_ = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  lock = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        locked;
    logic [7:0]  q;
    int          n_vec = 0;
    int          n_err = 0;

    dfr_wr_arb #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .reset_(reset_), .clr(clr), .req(req), .lock(lock),
        .wdata(wdata), .ack(ack), .owner(owner), .locked(locked), .q(q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string tag, input logic [3:0] e_ack, input logic [7:0] e_q,
                           input logic e_locked, input logic [1:0] e_owner);
        check({tag, ".ack"}, 32'(ack), 32'(e_ack));
        check({tag, ".q"}, 32'(q), 32'(e_q));
        check({tag, ".locked"}, 32'(locked), 32'(e_locked));
        check({tag, ".owner"}, 32'(owner), 32'(e_owner));
    endtask

    initial begin
        logic [3:0] rr_ack [5];
        logic [7:0] rr_q [5];
        rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_q   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        #1 reset_ = 1'b0;
        #1 expect4("reset", 4'b0000, 8'h00, 1'b0, 2'd3);
        req = 4'b1111;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        step();
        step();
        expect4("reset_hold", 4'b0000, 8'h00, 1'b0, 2'd3);
        @(negedge clk) reset_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect4($sformatf("rr%0d", i), rr_ack[i], rr_q[i], 1'b0, 2'(i % 4));
        end
        req = 4'b0110;
        lock = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            expect4($sformatf("lock%0d", i), 4'b0010, 8'h22, 1'b1, 2'd1);
        end
        lock = 4'b0000;
        step();
        expect4("lock_final", 4'b0010, 8'h22, 1'b0, 2'd1);
        step();
        expect4("lock_next", 4'b0100, 8'h33, 1'b0, 2'd2);
        req = 4'b0001;
        lock = 4'b0010;
        step();
        expect4("lock_noreq", 4'b0001, 8'h11, 1'b0, 2'd0);
        lock = 4'b0001;
        step();
        expect4("lock0", 4'b0001, 8'h11, 1'b1, 2'd0);
        req = 4'b0100;
        lock = 4'b0000;
        step();
        expect4("unlock_noreq", 4'b0000, 8'h11, 1'b0, 2'd0);
        step();
        expect4("resume", 4'b0100, 8'h33, 1'b0, 2'd2);
        req = 4'b0001;
        wdata[7:0] = 8'hAA;
        clr = 1'b1;
        step();
        expect4("clr", 4'b0000, 8'h00, 1'b0, 2'd2);
        clr = 1'b0;
        step();
        expect4("post_clr", 4'b0001, 8'hAA, 1'b0, 2'd0);
        req = 4'b1000;
        step();
        expect4("set_ptr3", 4'b1000, 8'h44, 1'b0, 2'd3);
        req = 4'b1001;
        step();
        expect4("wrap0", 4'b0001, 8'hAA, 1'b0, 2'd0);
        step();
        expect4("wrap3", 4'b1000, 8'h44, 1'b0, 2'd3);
        req = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            wdata[23:16] = 8'(k);
            step();
            expect4($sformatf("solo%0d", k), 4'b0100, 8'(k), 1'b0, 2'd2);
        end
        req = 4'b0010;
        lock = 4'b0010;
        wdata[15:8] = 8'h5C;
        step();
        expect4("pre_rst", 4'b0010, 8'h5C, 1'b1, 2'd1);
        #3 reset_ = 1'b0;
        #1 expect4("async_rst", 4'b0000, 8'h00, 1'b0, 2'd3);
        step();
        expect4("rst_nowrite", 4'b0000, 8'h00, 1'b0, 2'd3);
        req = 4'b1000;
        lock = 4'b0000;
        wdata[31:24] = 8'h77;
        @(negedge clk) reset_ = 1'b1;
        step();
        expect4("post_rst", 4'b1000, 8'h77, 1'b0, 2'd3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
